// File: rtl/rx_chan_buffer_pkg.sv
// Shared constants and types for the RX channel buffer and its neighbours.
package rx_chan_buffer_pkg;

  localparam int unsigned CTRL_SLOT          = 0;
  localparam int unsigned DEPTH_LOG2_DEFAULT = 10;
  // Packet payload size agreed with the downstream inband packet builder.
  localparam int unsigned PAYLOAD_WORDS      = 504;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWrI  = 2'd1,
    StWrQ  = 2'd2
  } seq_state_e;

  function automatic logic [3:0] last_slot(input logic [3:0] channels,
                                           input int unsigned num_chan);
    logic [3:0] cap;
    cap = 4'(num_chan);
    return (channels > cap) ? cap : channels;
  endfunction

endpackage

// File: rtl/rx_chan_buffer_if.sv
// Sample input, control write and slot read signals of the RX channel buffer.
interface rx_chan_buffer_if #(
  parameter int unsigned NUM_CHAN   = 2,
  parameter int unsigned DEPTH_LOG2 = 10
) ();

  logic [3:0]            channels;
  logic                  rxstrobe;
  logic [16*NUM_CHAN-1:0] ch_i;
  logic [16*NUM_CHAN-1:0] ch_q;
  logic [15:0]           cmd_data;
  logic                  cmd_wr;
  logic [3:0]            rd_select;
  logic                  chan_rdreq;
  logic [15:0]           chan_fifodata;
  logic [NUM_CHAN:0]     chan_empty;
  logic [DEPTH_LOG2-1:0] chan_usedw;
  logic [NUM_CHAN:0]     overrun;
  logic [NUM_CHAN:0]     clear_overrun;
  logic                  sample_lost;

  modport master (
    output channels, rxstrobe, ch_i, ch_q, cmd_data, cmd_wr, rd_select, chan_rdreq,
           clear_overrun,
    input  chan_fifodata, chan_empty, chan_usedw, overrun, sample_lost
  );

  modport slave (
    input  channels, rxstrobe, ch_i, ch_q, cmd_data, cmd_wr, rd_select, chan_rdreq,
           clear_overrun,
    output chan_fifodata, chan_empty, chan_usedw, overrun, sample_lost
  );

endinterface

// File: rtl/rx_slot_fifo.sv
// Single-clock show-ahead FIFO holding one slot's 16-bit words.
module rx_slot_fifo #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  rxclk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [15:0]           wdata,
  input  logic                  rd,
  output logic [15:0]           rdata,
  output logic [DEPTH_LOG2-1:0] usedw,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [15:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wp_q, rp_q, usedw_q;
  logic                  do_wr, do_rd;

  // One word is sacrificed so usedw never needs an extra bit.
  assign full  = (usedw_q == '1);
  assign empty = (usedw_q == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem_q[rp_q];
  assign usedw = usedw_q;

  always_ff @(posedge rxclk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      usedw_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      if (do_wr && !do_rd) begin
        usedw_q <= usedw_q + 1'b1;
      end else if (do_rd && !do_wr) begin
        usedw_q <= usedw_q - 1'b1;
      end
    end
  end

  always_ff @(posedge rxclk) begin
    if (do_wr) mem_q[wp_q] <= wdata;
  end

endmodule

// File: rtl/rx_chan_buffer.sv
// Per-slot buffering of control words and I/Q sample pairs ahead of the RX packet builder.
module rx_chan_buffer
  import rx_chan_buffer_pkg::*;
#(
  parameter int unsigned NUM_CHAN   = 2,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input logic rxclk,
  input logic reset,
  rx_chan_buffer_if.slave bus
);

  localparam int unsigned NumSlots = NUM_CHAN + 1;
  // A slot can take an I/Q pair while at most 2^DEPTH_LOG2 - 3 words are in use.
  localparam logic [DEPTH_LOG2-1:0] PairLimit = DEPTH_LOG2'((2 ** DEPTH_LOG2) - 3);

  seq_state_e             state_q, state_d;
  logic [3:0]             cur_q, cur_d;
  logic [3:0]             last;
  logic [16*NUM_CHAN-1:0] samp_i_q, samp_q_q;
  logic                   latch, seq_wr, seq_q_word, seq_drop, cur_room2;
  logic [NUM_CHAN:0]      overrun_q, sample_lost_unused;
  logic                   sample_lost_q;

  logic [NUM_CHAN:0]      slot_wr, slot_rd, slot_full, slot_empty, slot_room2, ovr_set;
  logic [15:0]            slot_wdata [NumSlots];
  logic [15:0]            slot_rdata [NumSlots];
  logic [DEPTH_LOG2-1:0]  slot_usedw [NumSlots];

  assign last = last_slot(bus.channels, NUM_CHAN);
  assign sample_lost_unused = '0;

  always_comb begin
    cur_room2 = 1'b0;
    for (int k = 1; k < NumSlots; k++) begin
      if (cur_q == 4'(k)) cur_room2 = slot_room2[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    latch      = 1'b0;
    seq_wr     = 1'b0;
    seq_q_word = 1'b0;
    seq_drop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.rxstrobe) begin
          latch = 1'b1;
          cur_d = 4'd1;
          if (bus.channels != 4'd0) state_d = StWrI;
        end
      end
      StWrI: begin
        if (cur_room2) begin
          seq_wr  = 1'b1;
          state_d = StWrQ;
        end else begin
          // No room for the whole pair: drop both words rather than store a lone I.
          seq_drop = 1'b1;
          if (cur_q == last) begin
            state_d = StIdle;
          end else begin
            cur_d   = cur_q + 4'd1;
            state_d = StWrI;
          end
        end
      end
      StWrQ: begin
        seq_wr     = 1'b1;
        seq_q_word = 1'b1;
        if (cur_q == last) begin
          state_d = StIdle;
        end else begin
          cur_d   = cur_q + 4'd1;
          state_d = StWrI;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state_q       <= StIdle;
      cur_q         <= '0;
      samp_i_q      <= '0;
      samp_q_q      <= '0;
      overrun_q     <= '0;
      sample_lost_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      if (latch) begin
        samp_i_q <= bus.ch_i;
        samp_q_q <= bus.ch_q;
      end
      overrun_q     <= (overrun_q & ~bus.clear_overrun) | ovr_set;
      sample_lost_q <= bus.rxstrobe && (state_q != StIdle);
    end
  end

  for (genvar k = 0; k < NumSlots; k++) begin : g_slot
    if (k == CTRL_SLOT) begin : g_ctrl
      assign slot_wr[k]    = bus.cmd_wr;
      assign slot_wdata[k] = bus.cmd_data;
      assign ovr_set[k]    = bus.cmd_wr && slot_full[k];
    end else begin : g_data
      assign slot_wr[k]    = seq_wr && (cur_q == 4'(k));
      assign slot_wdata[k] = seq_q_word ? samp_q_q[16*(k-1) +: 16] : samp_i_q[16*(k-1) +: 16];
      assign ovr_set[k]    = seq_drop && (cur_q == 4'(k));
    end

    assign slot_rd[k]    = bus.chan_rdreq && (bus.rd_select == 4'(k));
    assign slot_room2[k] = (slot_usedw[k] <= PairLimit);

    rx_slot_fifo #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
      .rxclk (rxclk),
      .reset (reset),
      .wr    (slot_wr[k]),
      .wdata (slot_wdata[k]),
      .rd    (slot_rd[k]),
      .rdata (slot_rdata[k]),
      .usedw (slot_usedw[k]),
      .full  (slot_full[k]),
      .empty (slot_empty[k])
    );
  end

  // Out-of-range selects read as an empty, all-zero slot.
  always_comb begin
    bus.chan_fifodata = '0;
    bus.chan_usedw    = '0;
    for (int k = 0; k < NumSlots; k++) begin
      if (bus.rd_select == 4'(k)) begin
        bus.chan_fifodata = slot_rdata[k];
        bus.chan_usedw    = slot_usedw[k];
      end
    end
  end

  assign bus.chan_empty  = slot_empty;
  assign bus.overrun     = overrun_q | sample_lost_unused;
  assign bus.sample_lost = sample_lost_q;

endmodule

// File: tb/tb_rx_chan_buffer.sv
// Scoreboard bench for rx_chan_buffer: per-slot expected-word queues.
module tb_rx_chan_buffer;
  import rx_chan_buffer_pkg::*;

  localparam int unsigned NC = 2;
  localparam int unsigned DL = 10;

  logic rxclk = 1'b0;
  logic reset;
  always #5 rxclk = ~rxclk;

  rx_chan_buffer_if #(.NUM_CHAN(NC), .DEPTH_LOG2(DL)) bus ();

  rx_chan_buffer #(
    .NUM_CHAN  (NC),
    .DEPTH_LOG2(DL)
  ) dut (
    .rxclk(rxclk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] sb0[$], sb1[$], sb2[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic sb_push(input int slot, input logic [15:0] w);
    case (slot)
      0: sb0.push_back(w);
      1: sb1.push_back(w);
      default: sb2.push_back(w);
    endcase
  endtask

  function automatic int sb_size(input int slot);
    case (slot)
      0: return sb0.size();
      1: return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic logic [15:0] sb_front(input int slot);
    case (slot)
      0: return sb0[0];
      1: return sb1[0];
      default: return sb2[0];
    endcase
  endfunction

  task automatic sb_drop(input int slot);
    logic [15:0] w;
    case (slot)
      0: w = sb0.pop_front();
      1: w = sb1.pop_front();
      default: w = sb2.pop_front();
    endcase
  endtask

  // Compare head word and count against the model, then pop one word.
  task automatic pop_check(input int slot);
    bus.rd_select = 4'(slot);
    #1;
    if (sb_size(slot) == 0) begin
      check("pop_model_empty", 32'(sb_size(slot)), 32'd1);
    end else begin
      check("head_data", 32'(bus.chan_fifodata), 32'(sb_front(slot)));
      check("head_usedw", 32'(bus.chan_usedw), 32'(sb_size(slot)));
      bus.chan_rdreq = 1'b1;
      tick();
      bus.chan_rdreq = 1'b0;
      sb_drop(slot);
    end
  endtask

  task automatic usedw_check(input int slot, input string tag);
    bus.rd_select = 4'(slot);
    #1;
    check(tag, 32'(bus.chan_usedw), 32'(sb_size(slot)));
  endtask

  task automatic strobe(input logic [15:0] i0, input logic [15:0] q0,
                        input logic [15:0] i1, input logic [15:0] q1);
    bus.ch_i     = {i1, i0};
    bus.ch_q     = {q1, q0};
    bus.rxstrobe = 1'b1;
    tick();
    bus.rxstrobe = 1'b0;
  endtask

  initial begin
    int lost_cnt;
    logic [15:0] w;

    reset = 1'b1;
    bus.channels = 4'd2;
    bus.rxstrobe = 1'b0;
    bus.ch_i = '0;
    bus.ch_q = '0;
    bus.cmd_data = '0;
    bus.cmd_wr = 1'b0;
    bus.rd_select = 4'd0;
    bus.chan_rdreq = 1'b0;
    bus.clear_overrun = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_empty", 32'(bus.chan_empty), 32'h7);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    check("rst_lost", 32'(bus.sample_lost), 32'h0);
    for (int s = 0; s < 3; s++) usedw_check(s, "rst_usedw");

    // One strobe, two channels, first-word latency
    bus.channels = 4'd2;
    strobe(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    sb_push(1, 16'h1111); sb_push(1, 16'h2222);
    sb_push(2, 16'h3333); sb_push(2, 16'h4444);
    check("lat_empty_c1", 32'(bus.chan_empty[1]), 32'h1);
    tick();
    check("lat_empty_c2", 32'(bus.chan_empty[1]), 32'h0);
    repeat (4) tick();
    pop_check(1); pop_check(1); pop_check(2); pop_check(2);
    usedw_check(1, "basic_usedw1_end");
    usedw_check(2, "basic_usedw2_end");
    check("basic_empty_end", 32'(bus.chan_empty), 32'h7);

    // Fill slot 1 to 1022 words
    bus.channels = 4'd1;
    for (int i = 0; i < 511; i++) begin
      strobe(16'(i), ~16'(i), 16'h0, 16'h0);
      sb_push(1, 16'(i));
      sb_push(1, ~16'(i));
      tick(); tick();
    end
    usedw_check(1, "fill_usedw");
    check("fill_no_overrun", 32'(bus.overrun), 32'h0);
    // One more strobe drops the pair; a simultaneous clear loses to the set
    strobe(16'hDEAD, 16'hBEEF, 16'h0, 16'h0);
    bus.clear_overrun = 3'b010;
    tick();
    bus.clear_overrun = '0;
    tick();
    check("drop_overrun", 32'(bus.overrun), 32'h2);
    usedw_check(1, "drop_usedw");
    bus.clear_overrun = 3'b010;
    tick();
    bus.clear_overrun = '0;
    check("clear_overrun", 32'(bus.overrun), 32'h0);

    // Drain down to 5 words
    for (int n = 0; n < 1017; n++) pop_check(1);
    usedw_check(1, "wrap_start_usedw");

    // Reads concurrent with writes across the pointer wrap
    bus.rd_select = 4'd1;
    for (int s = 0; s < 10; s++) begin
      strobe(16'h5000 + 16'(s), 16'h6000 + 16'(s), 16'h0, 16'h0);
      bus.chan_rdreq = 1'b1;
      #1;
      check("wrap_head_i", 32'(bus.chan_fifodata), 32'(sb1[0]));
      tick();
      w = sb1.pop_front();
      sb1.push_back(16'h5000 + 16'(s));
      check("wrap_usedw_i", 32'(bus.chan_usedw), 32'd5);
      check("wrap_head_q", 32'(bus.chan_fifodata), 32'(sb1[0]));
      tick();
      w = sb1.pop_front();
      sb1.push_back(16'h6000 + 16'(s));
      bus.chan_rdreq = 1'b0;
      #1;
      check("wrap_usedw_q", 32'(bus.chan_usedw), 32'd5);
    end
    for (int n = 0; n < 5; n++) pop_check(1);
    check("wrap_empty", 32'(bus.chan_empty[1]), 32'h1);

    // Back-to-back strobes
    bus.channels = 4'd2;
    bus.ch_i = {16'hA3A3, 16'hA1A1};
    bus.ch_q = {16'hA4A4, 16'hA2A2};
    bus.rxstrobe = 1'b1;
    tick();
    bus.ch_i = {16'hB3B3, 16'hB1B1};
    bus.ch_q = {16'hB4B4, 16'hB2B2};
    tick();
    bus.rxstrobe = 1'b0;
    lost_cnt = int'(bus.sample_lost);
    for (int n = 0; n < 6; n++) begin
      tick();
      lost_cnt += int'(bus.sample_lost);
    end
    check("lost_pulses", 32'(lost_cnt), 32'd1);
    sb_push(1, 16'hA1A1); sb_push(1, 16'hA2A2);
    sb_push(2, 16'hA3A3); sb_push(2, 16'hA4A4);
    usedw_check(1, "lost_usedw1");
    usedw_check(2, "lost_usedw2");
    pop_check(1); pop_check(1); pop_check(2); pop_check(2);
    check("lost_empty", 32'(bus.chan_empty), 32'h7);

    // Control slot, including overflow
    bus.cmd_wr = 1'b1;
    bus.cmd_data = 16'hABCD;
    tick();
    bus.cmd_data = 16'h1234;
    tick();
    sb_push(0, 16'hABCD); sb_push(0, 16'h1234);
    for (int n = 0; n < 1021; n++) begin
      bus.cmd_data = 16'h7000 + 16'(n);
      sb_push(0, 16'h7000 + 16'(n));
      tick();
    end
    check("cmd_no_overrun", 32'(bus.overrun), 32'h0);
    bus.cmd_data = 16'hFFFF;
    tick();
    bus.cmd_wr = 1'b0;
    check("cmd_overrun", 32'(bus.overrun), 32'h1);
    usedw_check(0, "cmd_full_usedw");
    bus.clear_overrun = 3'b001;
    tick();
    bus.clear_overrun = '0;
    check("cmd_clear", 32'(bus.overrun), 32'h0);
    for (int n = 0; n < 1023; n++) pop_check(0);
    check("cmd_empty", 32'(bus.chan_empty[0]), 32'h1);
    bus.rd_select = 4'd0;
    bus.chan_rdreq = 1'b1;
    tick();
    bus.chan_rdreq = 1'b0;
    usedw_check(0, "cmd_empty_rd_usedw");
    bus.rd_select = 4'd3;
    bus.chan_rdreq = 1'b1;
    #1;
    check("oob_data", 32'(bus.chan_fifodata), 32'h0);
    check("oob_usedw", 32'(bus.chan_usedw), 32'h0);
    tick();
    bus.chan_rdreq = 1'b0;

    // Reset in the middle of a burst
    bus.cmd_wr = 1'b1;
    bus.cmd_data = 16'h0C0C;
    tick();
    bus.cmd_wr = 1'b0;
    strobe(16'hC1C1, 16'hC2C2, 16'hC3C3, 16'hC4C4);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb0.delete(); sb1.delete(); sb2.delete();
    check("mid_rst_empty", 32'(bus.chan_empty), 32'h7);
    check("mid_rst_overrun", 32'(bus.overrun), 32'h0);
    for (int s = 0; s < 3; s++) usedw_check(s, "mid_rst_usedw");
    strobe(16'hD1D1, 16'hD2D2, 16'hD3D3, 16'hD4D4);
    sb_push(1, 16'hD1D1); sb_push(1, 16'hD2D2);
    sb_push(2, 16'hD3D3); sb_push(2, 16'hD4D4);
    lost_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      lost_cnt += int'(bus.sample_lost);
    end
    check("post_rst_lost", 32'(lost_cnt), 32'd0);
    pop_check(1); pop_check(1); pop_check(2); pop_check(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_chan_buffer.md
Name: rx_chan_buffer

Overview:
- Sits directly upstream of the inband RX packet builder.
- Accepts decimated I/Q samples from up to NUM_CHAN receive channels, plus 16-bit control/reply words.
- Stores each stream in its own slot FIFO. Slot 0 is control; slot k (k≥1) is RX channel k-1.
- Presents the slot chosen by rd_select as a show-ahead 16-bit read port, with per-slot empty flags and a muxed used-word count.

Parameters:
- NUM_CHAN, 2, number of RX data channels; slots are 0..NUM_CHAN.
- DEPTH_LOG2, 10, address width of each slot FIFO; usable capacity is 2^DEPTH_LOG2 - 1 words.

Ports:
- rxclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- channels  in  4  highest active slot index; slots above it are never written.
- rxstrobe  in  1  one-cycle pulse: a new sample is valid on all ch_i/ch_q.
- ch_i  in  16*NUM_CHAN  packed I samples; channel n occupies bits [16n+15:16n].
- ch_q  in  16*NUM_CHAN  packed Q samples, same layout as ch_i.
- cmd_data  in  16  control reply word.
- cmd_wr  in  1  write cmd_data into slot 0.
- rd_select  in  4  slot presented on the read port.
- chan_rdreq  in  1  pop the head word of slot rd_select.
- chan_fifodata  out  16  head word of slot rd_select (show-ahead).
- chan_empty  out  NUM_CHAN+1  per-slot empty flags.
- chan_usedw  out  DEPTH_LOG2  word count of slot rd_select.
- overrun  out  NUM_CHAN+1  sticky per-slot drop flags.
- clear_overrun  in  NUM_CHAN+1  per-slot clear pulses for overrun.
- sample_lost  out  1  one-cycle pulse when rxstrobe arrives while the sequencer is busy.

Behaviour:
- Reset:
  - All pointers and counts go to 0; chan_empty all 1s; overrun 0; sample_lost 0.
  - Write sequencer goes to IDLE; latched samples are discarded.
  - Stored data is flushed. Reset applies mid-burst with no partial state kept.
- Slot FIFO:
  - Circular RAM, write pointer wp, read pointer rp, count usedw.
  - Full when usedw == 2^DEPTH_LOG2-1; empty when usedw == 0.
  - Same-cycle read and write: usedw unchanged, both pointers advance.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- Read port:
  - chan_fifodata shows mem[rp] of the selected slot combinationally.
  - A pop with chan_rdreq=1 advances rp, so the next word is visible the following cycle.
  - rdreq on an empty slot is ignored (no pointer or count change).
  - rd_select > NUM_CHAN: chan_fifodata=0, chan_usedw=0, rdreq ignored.
- Write sequencer (states IDLE, WR_I, WR_Q):
  - IDLE: on rxstrobe, latch ch_i/ch_q; set cur=1; go to WR_I if channels≥1, else stay in IDLE.
  - WR_I: if slot cur has ≥2 free words, write I and go to WR_Q. Otherwise drop both words, set overrun[cur], and advance cur.
  - WR_Q: write Q, then advance cur.
  - Advance: if cur == min(channels, NUM_CHAN) go to IDLE; else cur+1 and go to WR_I.
  - I and Q are always written as an adjacent pair; a lone I is never stored.
- Timing: a strobe is fully written in 2*channels cycles; the first word appears (empty deasserts) 2 cycles after rxstrobe.
- rxstrobe while not in IDLE: the strobe is ignored, sample_lost pulses for 1 cycle, and the current write sequence continues.
- Control slot:
  - cmd_wr writes slot 0 whenever the slot is not full; it is independent of the sequencer and may coincide with a read.
  - cmd_wr while full: word dropped, overrun[0] set.
- overrun clear:
  - clear_overrun[k] clears bit k.
  - A set and a clear in the same cycle: set wins.

Decomposition:
- Shared package: slot index constants (CTRL_SLOT=0), sequencer state encodings, DEPTH_LOG2 default, and the 504-word payload constant shared with the packet builder.
- One sub-module, rx_slot_fifo: a single-clock show-ahead FIFO with usedw, full and empty, instantiated NUM_CHAN+1 times via generate.

Test Plan:
- Reset, then one rxstrobe with channels=2, ch0=(0x1111,0x2222), ch1=(0x3333,0x4444) -> slot1 reads 0x1111,0x2222; slot2 reads 0x3333,0x4444; usedw goes 2→0 as they are popped.
- 511 strobes with no reads (slot1 holds 1022 words) -> one more strobe: slot1 drops the pair, overrun[1]=1, usedw stays 1022; clear_overrun[1] clears the flag.
- rxstrobe on two consecutive cycles with channels=2 -> sample_lost pulses once; only the first sample is stored.
- With slot1 at usedw=5, continuous rdreq on slot1 concurrent with writes -> usedw stays constant; data order is preserved across the pointer wrap at 1023→0.
- cmd_wr with 0xABCD, 0x1234, then rd_select=0 -> show-ahead 0xABCD, then 0x1234 after a pop; chan_empty[0]=1 after the second pop; rdreq on empty leaves usedw at 0.
- Assert reset mid-WR_Q -> next cycle all chan_empty=1, usedw=0, overrun=0, sequencer in IDLE.
